hub_div_issuer: RTL and testbench

Initiator side of the FPnew-style divider handshake. Sits between a requesting core/LSU-style client and the HUB divider unit; buffers up to DEPTH divide requests, issues them one at a time on the `in_valid/in_ready` channel, captures the result on the `out_valid/out_ready` channel, and returns it to the client with its tag. Only one division is in flight at a time, matching the iterative divider.

---
 rtl/hub_div_issuer_if.sv | 38 +++
 rtl/hub_div_issuer.sv | 192 +++++++++++++++++++
 tb/tb_hub_div_issuer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub_div_issuer_if.sv
// Client request/response and divider operand/result channels of the HUB divide issuer.
// master = issuer side, slave = client plus divider side.
interface hub_div_issuer_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [WIDTH-1:0]      req_x_i;
    logic [WIDTH-1:0]      req_d_i;
    logic [TAG_W-1:0]      req_tag_i;
    logic [2:0][WIDTH-1:0] operands_o;
    logic                  in_valid_o;
    logic                  in_ready_i;
    logic [WIDTH-1:0]      result_i;
    logic                  out_valid_i;
    logic                  out_ready_o;
    logic                  busy_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WIDTH-1:0]      rsp_result_o;
    logic [TAG_W-1:0]      rsp_tag_o;
    logic                  rsp_err_o;

    modport master (
        input  req_valid_i, req_x_i, req_d_i, req_tag_i,
        input  in_ready_i, result_i, out_valid_i, busy_i, rsp_ready_i,
        output req_ready_o, operands_o, in_valid_o, out_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o
    );

    modport slave (
        output req_valid_i, req_x_i, req_d_i, req_tag_i,
        output in_ready_i, result_i, out_valid_i, busy_i, rsp_ready_i,
        input  req_ready_o, operands_o, in_valid_o, out_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o
    );
endinterface

// File: rtl/hub_div_issuer.sv
// Queues client divide requests and issues them one at a time to the iterative HUB divider.
// Optional result-wait watchdog: define HUB_DIV_WATCHDOG_EN.
package fpnew_pkg;
    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;
endpackage

module hub_div_issuer #(
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  flush_o,
    output fpnew_pkg::operation_e op_o,
    output logic                  op_mod_o,
    hub_div_issuer_if.master      bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    req_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    state_e           r_state;
    req_t             r_cur;
    logic [WIDTH-1:0] r_res;
    logic             r_in_valid;
    logic             r_out_ready;
    logic             r_rsp_valid;
    logic             r_flush;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    req_t             w_head;
    logic             w_unused_busy;

`ifdef HUB_DIV_WATCHDOG_EN
    localparam int    WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]  r_wd;
    logic             r_err;
`else
    localparam int    w_unused_timeout = TIMEOUT;
`endif

    assign w_empty         = (r_cnt == '0);
    assign bus.req_ready_o = (r_cnt < FULL_CNT);
    assign w_push          = bus.req_valid_i && bus.req_ready_o && !flush_i;
    // The head leaves the FIFO either from IDLE or straight out of a completed response.
    assign w_pop           = !w_empty && !flush_i &&
                             ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready_i));
    assign w_head          = r_mem[r_rptr];
    assign w_unused_busy   = bus.busy_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{x: bus.req_x_i, d: bus.req_d_i, tag: bus.req_tag_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_res       <= '0;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_flush     <= 1'b0;
`ifdef HUB_DIV_WATCHDOG_EN
            r_wd        <= '0;
            r_err       <= 1'b0;
`endif
        end else if (flush_i) begin
            r_state     <= S_IDLE;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_flush     <= 1'b1;
`ifdef HUB_DIV_WATCHDOG_EN
            r_wd        <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur      <= w_head;
                        r_in_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.in_ready_i) begin
                        r_in_valid  <= 1'b0;
                        r_out_ready <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.out_valid_i) begin
                        r_res       <= bus.result_i;
                        r_out_ready <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
`ifdef HUB_DIV_WATCHDOG_EN
                        r_wd        <= '0;
                        r_err       <= 1'b0;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        // Divider is presumed hung: answer with an error and flush it.
                        r_res       <= '0;
                        r_err       <= 1'b1;
                        r_flush     <= 1'b1;
                        r_out_ready <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_wd        <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd        <= r_wd + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_cur      <= w_head;
                            r_in_valid <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.operands_o[0] = r_cur.x;
    assign bus.operands_o[1] = r_cur.d;
    assign bus.operands_o[2] = '0;
    assign bus.in_valid_o    = r_in_valid;
    assign bus.out_ready_o   = r_out_ready;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_result_o  = r_res;
    assign bus.rsp_tag_o     = r_cur.tag;
`ifdef HUB_DIV_WATCHDOG_EN
    assign bus.rsp_err_o     = r_err;
`else
    assign bus.rsp_err_o     = 1'b0;
`endif
    assign flush_o           = r_flush;
    assign op_o              = fpnew_pkg::DIV;
    assign op_mod_o          = 1'b0;
endmodule

// File: tb/tb_hub_div_issuer.sv
// Randomized bench for hub_div_issuer: behavioural divider stand-in plus in-order response scoreboard.
module tb_hub_div_issuer;
    localparam int WIDTH   = 16;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush_i = 1'b0;
    logic       flush_o;
    logic [3:0] op;
    logic       op_mod;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Divider stand-in controls, written only by the main sequence.
    bit div_en   = 1'b0;
    bit div_mute = 1'b0;
    int div_lat  = 0;
    int spur_seq = 0;

    hub_div_issuer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    hub_div_issuer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush_i),
        .flush_o (flush_o),
        .op_o    (op),
        .op_mod_o(op_mod),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] div_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d);
        if (x == 16'h3C00 && d == 16'h4000) return 16'h3800;
        return x ^ {d[7:0], d[15:8]} ^ 16'h1357;
    endfunction

    // Iterative divider: accepts when idle, answers div_lat+1 edges after acceptance with a 1-cycle pulse.
    initial begin : divider
        bit               pend;
        int               cnt;
        int               spur_done;
        logic [WIDTH-1:0] pres;
        pend = 1'b0; cnt = 0; spur_done = 0; pres = '0;
        bus.in_ready_i  = 1'b0;
        bus.out_valid_i = 1'b0;
        bus.result_i    = '0;
        bus.busy_i      = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.in_ready_i && bus.in_valid_o && !div_mute) begin
                pend = 1'b1;
                cnt  = div_lat;
                pres = div_model(bus.operands_o[0], bus.operands_o[1]);
            end
            @(posedge clk);
            #1;
            bus.out_valid_i = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    bus.out_valid_i = 1'b1;
                    bus.result_i    = pres;
                    pend            = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spur_seq != spur_done) begin
                spur_done       = spur_seq;
                bus.out_valid_i = 1'b1;
                bus.result_i    = 16'hDEAD;
            end
            bus.in_ready_i = div_en && !pend;
            bus.busy_i     = pend;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.req_ready_o, bus.in_valid_o, bus.out_ready_o, bus.rsp_valid_o, bus.rsp_err_o, flush_o, op_mod} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 1000000", {bus.req_ready_o, bus.in_valid_o, bus.out_ready_o, bus.rsp_valid_o, bus.rsp_err_o, flush_o, op_mod});
        end
        n_tests++;
        if ({bus.operands_o, bus.rsp_result_o, bus.rsp_tag_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {bus.operands_o, bus.rsp_result_o, bus.rsp_tag_o});
        end
        n_tests++;
        if (op !== 4'd4) begin  // DIV encoding
            n_fail++;
            $display("FAIL reset_op: got %0d want 4", op);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.req_ready_o, bus.in_valid_o, bus.rsp_valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset: got %b want 100", {bus.req_ready_o, bus.in_valid_o, bus.rsp_valid_o});
        end
    endtask

    task automatic test_single();
        bit ok;
        div_en = 1'b1; div_lat = 9;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_x_i = 16'h3C00; bus.req_d_i = 16'h4000; bus.req_tag_i = 4'd3;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n_tests++;
        if (bus.in_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_issue: in_valid got %b want 0", bus.in_valid_o);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.in_valid_o, bus.operands_o} !== {1'b1, 16'h0000, 16'h4000, 16'h3C00}) begin
            n_fail++;
            $display("FAIL single_issue: got %b/%h want 1/000040003c00", bus.in_valid_o, bus.operands_o);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid_i) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok || bus.out_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait: seen %b out_ready %b rsp_valid %b want 1 1 0", ok, bus.out_ready_o, bus.rsp_valid_o);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_tag_o, bus.rsp_err_o} !== {1'b1, 16'h3800, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got %b %h %0d %b want 1 3800 3 0", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_tag_o, bus.rsp_err_o);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_tag_o} !== {1'b1, 16'h3800, 4'd3}) begin
            n_fail++;
            $display("FAIL single_hold: got %b %h %0d want 1 3800 3", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_tag_o);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        n_tests++;
        if ({bus.rsp_valid_o, bus.in_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done: rsp_valid/in_valid got %b want 00", {bus.rsp_valid_o, bus.in_valid_o});
        end
    endtask

    // Divider refuses everything: the FIFO fills behind the one request held in the issue slot.
    task automatic test_full();
        int               acc;
        int               got;
        logic [WIDTH-1:0] fx, fd;
        exp_t             e;
        div_en = 1'b0; acc = 0; got = 0; fx = '0; fd = '0;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_x_i     = 16'($urandom);
            bus.req_d_i     = 16'($urandom);
            bus.req_tag_i   = acc[TAG_W-1:0];
            if (bus.req_ready_o) begin
                if (acc == 0) begin fx = bus.req_x_i; fd = bus.req_d_i; end
                exp_q.push_back('{tag: bus.req_tag_i, res: div_model(bus.req_x_i, bus.req_d_i)});
                acc++;
            end
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n_tests++;
        if (acc != DEPTH + 1 || bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_accept: accepted %0d ready %b want %0d 0", acc, bus.req_ready_o, DEPTH + 1);
        end
        n_tests++;
        if ({bus.in_valid_o, bus.operands_o[0], bus.operands_o[1]} !== {1'b1, fx, fd}) begin
            n_fail++;
            $display("FAIL full_hold_issue: got %b %h %h want 1 %h %h", bus.in_valid_o, bus.operands_o[0], bus.operands_o[1], fx, fd);
        end
        div_en = 1'b1; div_lat = 1;
        for (int c = 0; c < 400 && got < acc; c++) begin
            @(negedge clk);
            bus.rsp_ready_i = 1'($urandom_range(0, 1));
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                e = exp_q.pop_front();
                got++;
                n_tests++;
                if ({bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_err_o} !== {e.tag, e.res, 1'b0}) begin
                    n_fail++;
                    $display("FAIL full_order: got tag %0d res %h err %b want tag %0d res %h err 0", bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_err_o, e.tag, e.res);
                end
            end
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        n_tests++;
        if (got != DEPTH + 1) begin
            n_fail++;
            $display("FAIL full_drain: got %0d responses want %0d", got, DEPTH + 1);
        end
    endtask

    task automatic test_rsp_stall();
        bit               ok;
        logic [WIDTH-1:0] hr;
        logic [TAG_W-1:0] ht;
        bit               moved;
        exp_t             e;
        div_en = 1'b1; div_lat = 2; moved = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_x_i     = 16'($urandom);
            bus.req_d_i     = 16'($urandom);
            bus.req_tag_i   = 4'(8 + i);
            exp_q.push_back('{tag: bus.req_tag_i, res: div_model(bus.req_x_i, bus.req_d_i)});
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (bus.rsp_valid_o) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || {bus.rsp_tag_o, bus.rsp_result_o} !== {e.tag, e.res}) begin
                n_fail++;
                $display("FAIL stall_rsp%0d: seen %b tag %0d res %h want tag %0d res %h", r, ok, bus.rsp_tag_o, bus.rsp_result_o, e.tag, e.res);
            end
            if (r == 0) begin
                hr = bus.rsp_result_o; ht = bus.rsp_tag_o;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if ({bus.rsp_valid_o, bus.in_valid_o, bus.rsp_result_o, bus.rsp_tag_o} !== {1'b1, 1'b0, hr, ht}) moved = 1'b1;
                end
                n_tests++;
                if (moved) begin
                    n_fail++;
                    $display("FAIL stall_hold: response moved or issue started while held; now %b %b %h %0d want 1 0 %h %0d", bus.rsp_valid_o, bus.in_valid_o, bus.rsp_result_o, bus.rsp_tag_o, hr, ht);
                end
            end
            bus.rsp_ready_i = 1'b1;
            @(negedge clk);
            bus.rsp_ready_i = 1'b0;
            if (r == 0) begin
                n_tests++;
                if ({bus.in_valid_o, bus.rsp_valid_o} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL stall_b2b: in_valid/rsp_valid got %b want 10", {bus.in_valid_o, bus.rsp_valid_o});
                end
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        bit leak;
        div_en = 1'b1; div_lat = 29; leak = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_x_i     = 16'($urandom);
            bus.req_d_i     = 16'($urandom);
            bus.req_tag_i   = 4'(i);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_ready_o) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL flush_reach_wait: out_ready never rose");
        end
        flush_i = 1'b1;
        bus.req_valid_i = 1'b1; bus.req_tag_i = 4'd9;
        @(negedge clk);
        flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        n_tests++;
        if ({flush_o, bus.req_ready_o, bus.in_valid_o, bus.out_ready_o, bus.rsp_valid_o} !== 5'b11000) begin
            n_fail++;
            $display("FAIL flush_state: got %b want 11000", {flush_o, bus.req_ready_o, bus.in_valid_o, bus.out_ready_o, bus.rsp_valid_o});
        end
        @(negedge clk);
        n_tests++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pulse: flush_o got %b want 0 on second cycle", flush_o);
        end
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.in_valid_o || flush_o) leak = 1'b1;
        end
        n_tests++;
        if (leak || bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_quiet: activity after flush %b ready %b want 0 1", leak, bus.req_ready_o);
        end
    endtask

    task automatic test_spurious();
        bit               ok;
        bit               bad;
        logic [WIDTH-1:0] x, d;
        div_en = 1'b0; bad = 1'b0;
        spur_seq++;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.out_ready_o) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL spur_idle: response or wait seen got 1 want 0");
        end
        x = 16'($urandom); d = 16'($urandom);
        bus.req_valid_i = 1'b1; bus.req_x_i = x; bus.req_d_i = d; bus.req_tag_i = 4'd5;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        spur_seq++;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.in_valid_o, bus.rsp_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL spur_issue: in_valid/rsp_valid got %b want 10", {bus.in_valid_o, bus.rsp_valid_o});
        end
        div_en = 1'b1; div_lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok || {bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_err_o} !== {4'd5, div_model(x, d), 1'b0}) begin
            n_fail++;
            $display("FAIL spur_real: seen %b tag %0d res %h want tag 5 res %h", ok, bus.rsp_tag_o, bus.rsp_result_o, div_model(x, d));
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_random();
        int   sent;
        int   got;
        exp_t e;
        sent = 0; got = 0;
        exp_q.delete();
        for (int c = 0; c < 4000 && got < 40; c++) begin
            @(negedge clk);
            div_en          = ($urandom_range(0, 9) < 7);
            div_lat         = $urandom_range(0, 5);
            bus.rsp_ready_i = 1'($urandom_range(0, 1));
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: unexpected response tag %0d res %h", bus.rsp_tag_o, bus.rsp_result_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_err_o} !== {e.tag, e.res, 1'b0}) begin
                        n_fail++;
                        $display("FAIL rand_rsp: got tag %0d res %h err %b want tag %0d res %h err 0", bus.rsp_tag_o, bus.rsp_result_o, bus.rsp_err_o, e.tag, e.res);
                    end
                end
            end
            bus.req_valid_i = (sent < 40) && ($urandom_range(0, 1) == 1);
            bus.req_x_i     = 16'($urandom);
            bus.req_d_i     = 16'($urandom);
            bus.req_tag_i   = 4'($urandom);
            if (bus.req_valid_i && bus.req_ready_o) begin
                exp_q.push_back('{tag: bus.req_tag_i, res: div_model(bus.req_x_i, bus.req_d_i)});
                sent++;
            end
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
        n_tests++;
        if (got != 40 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d left %0d want 40 0", got, exp_q.size());
        end
    endtask

`ifdef HUB_DIV_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int j;
        div_en = 1'b1; div_mute = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_x_i = 16'h1111; bus.req_d_i = 16'h2222; bus.req_tag_i = 4'd7;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_ready_o) begin ok = 1'b1; break; end
        end
        j = 0;
        while (ok && !bus.rsp_valid_o && j < 200) begin
            @(negedge clk);
            j++;
        end
        n_tests++;
        if (!ok || j != TIMEOUT) begin
            n_fail++;
            $display("FAIL wd_time: waited %0d cycles in WAIT want %0d", j, TIMEOUT);
        end
        n_tests++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_result_o, bus.rsp_tag_o, flush_o} !== {1'b1, 1'b1, 16'h0000, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL wd_rsp: got %b %b %h %0d %b want 1 1 0000 7 1", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_result_o, bus.rsp_tag_o, flush_o);
        end
        @(negedge clk);
        n_tests++;
        if ({flush_o, bus.rsp_valid_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL wd_pulse: flush_o/rsp_valid got %b want 01", {flush_o, bus.rsp_valid_o});
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        div_mute = 1'b0;
    endtask
`endif

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_x_i     = '0;
        bus.req_d_i     = '0;
        bus.req_tag_i   = '0;
        bus.rsp_ready_i = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_rsp_stall();
        test_flush();
        test_spurious();
        test_random();
`ifdef HUB_DIV_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
